// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   localparam int          FETCH_ADDR_W = 8;
   localparam logic [31:0] HALT_WORD    = 32'h0000_0000;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fetch_state_e;

   typedef struct packed {
      logic [31:0]             instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched words; head visible combinationally, one-cycle fill latency.
// Flush wins over push; the producer's credit rule must never push into a full queue without a pop.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_dat,
   output fetch_entry_t o_dat,
   output logic         o_vld,
   output logic [1:0]   o_count
);
   fetch_entry_t r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_pop;

   assign w_pop   = i_pop && (r_count != 2'd0);
   assign o_vld   = (r_count != 2'd0);
   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + 2'(i_push) - 2'(w_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (i_push && !i_flush && !w_pop) |-> (r_count != 2'd2));
endmodule

// File: rtl/fetch_ctrl.sv
// PC owner and ROM issue sequencer: 1-cycle ROM latency absorbed, start-to-instr_valid is 3 cycles.
// Issue is credit-gated so in-flight plus queued words never exceed two while decode stalls.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int          SIZE      = 48,
   parameter int          ADDR_W    = FETCH_ADDR_W,
   parameter logic [31:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_start_pc,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic              o_rom_req,
   input  logic [31:0]       i_rom_data,
   output logic              o_instr_valid,
   input  logic              i_instr_ready,
   output logic [31:0]       o_instr,
   output logic [ADDR_W-1:0] o_instr_pc,
   output logic              o_busy,
   output logic              o_halted
);
   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(SIZE - 4);

   fetch_state_e      r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflight_pc;

   logic         w_start, w_redir, w_ret, w_halt_det, w_end, w_credit;
   logic         w_pop, w_push, w_flush;
   logic [1:0]   w_count;
   fetch_entry_t w_head, w_push_dat;

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_dat   (w_push_dat),
      .o_dat   (w_head),
      .o_vld   (o_instr_valid),
      .o_count (w_count)
   );

   assign o_instr    = w_head.instr;
   assign o_instr_pc = w_head.pc;
   assign o_rom_addr = r_pc;
   assign o_busy     = (r_state == RUN) || (r_state == DRAIN);
   assign o_halted   = (r_state == HALTED);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = o_instr_valid && i_instr_ready;
      w_start     = i_start && ((r_state == IDLE) || (r_state == HALTED));
      w_redir     = i_redirect_valid && o_busy;
      w_flush     = w_start || w_redir;
      // A return landing in the redirect cycle belongs to the abandoned path.
      w_ret       = r_inflight && !w_redir;
      w_halt_det  = w_ret && (i_rom_data == HALT_WORD);
      w_push      = w_ret && !w_halt_det;
      w_push_dat  = '{instr: i_rom_data, pc: r_inflight_pc};
      w_end       = (r_state == RUN) && (r_pc > LAST_PC);
      w_credit    = ({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
      o_rom_req   = (r_state == RUN) && !w_redir && !w_halt_det && !w_end && w_credit;

      if (w_start || w_redir)
         w_state_nxt = RUN;
      else if ((r_state == RUN) && (w_halt_det || w_end))
         w_state_nxt = DRAIN;
      else if ((r_state == DRAIN) && !r_inflight && (w_count == 2'd0))
         w_state_nxt = HALTED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= o_rom_req;
         if (o_rom_req)
            r_inflight_pc <= r_pc;
         if (w_start)
            r_pc <= {i_start_pc[ADDR_W-1:2], 2'b00};
         else if (w_redir)
            r_pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
         else if (o_rom_req)
            r_pc <= r_pc + ADDR_W'(4);
      end
   end
endmodule
